// File: rtl/result_uart_tx_pkg.sv
// Shared types and constants for the write-back result UART transmitter.
// Optional feature macro: RESULT_TX_PARITY_EN (adds an even-parity bit per frame).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } txState_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

`ifdef RESULT_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Start + data + optional parity + stop.
    localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + STOP_BITS;

    // Low byte when hi=0, high byte when hi=1.
    function automatic logic [7:0] selectByte(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses
// bit_tick on the last count of every bit. Held at zero when disabled so
// each new frame starts on a full bit period.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    // Free-run within a bit, wrap on the bit boundary, park at zero when idle.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            count <= '0;
        end else if (count == LAST_CNT) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_tick = enable && (count == LAST_CNT);

endmodule

// File: rtl/result_uart_tx.sv
// Sends each 16-bit write-back result as two UART frames, low byte first,
// and stalls fetch while a result is in flight.
// Optional feature macro: RESULT_TX_PARITY_EN (even parity bit after data).
module result_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        done_i,
    input  logic [15:0] result_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        stall_o,
    output logic        overrun_o
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    txState_t    state, stateNext;
    logic [2:0]  bitIdx, bitIdxNext;
    logic        byteSel, byteSelNext;
    logic [15:0] shiftReg, shiftRegNext;
    logic        overrun;
    logic        bitTick;
    logic        txBit;
    logic [7:0]  curByte;

    // Baud timer only runs while a frame is on the wire.
    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) baudCounter (
        .clk     (clk),
        .reset   (reset),
        .enable  (state != IDLE),
        .bit_tick(bitTick)
    );

    assign curByte = selectByte(shiftReg, byteSel);

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bitIdx   <= '0;
            byteSel  <= 1'b0;
            shiftReg <= '0;
        end else begin
            state    <= stateNext;
            bitIdx   <= bitIdxNext;
            byteSel  <= byteSelNext;
            shiftReg <= shiftRegNext;
        end
    end

    // A result arriving while busy is dropped but remembered until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (done_i && (state != IDLE)) begin
            overrun <= 1'b1;
        end
    end

    // Next-state and line-level decode; the line level depends only on
    // registered state so tx_o changes one cycle after the deciding edge.
    always_comb begin
        stateNext    = state;
        bitIdxNext   = bitIdx;
        byteSelNext  = byteSel;
        shiftRegNext = shiftReg;
        txBit        = 1'b1;

        case (state)
            IDLE: begin
                txBit = 1'b1;
                if (done_i) begin
                    shiftRegNext = result_i;
                    byteSelNext  = 1'b0;
                    bitIdxNext   = '0;
                    stateNext    = START;
                end
            end

            START: begin
                txBit = 1'b0;
                if (bitTick) begin
                    bitIdxNext = '0;
                    stateNext  = DATA;
                end
            end

            DATA: begin
                txBit = curByte[bitIdx];
                if (bitTick) begin
                    if (bitIdx == LAST_BIT) begin
                        bitIdxNext = '0;
`ifdef RESULT_TX_PARITY_EN
                        stateNext  = PARITY;
`else
                        stateNext  = STOP;
`endif
                    end else begin
                        bitIdxNext = bitIdx + 3'd1;
                    end
                end
            end

`ifdef RESULT_TX_PARITY_EN
            PARITY: begin
                // Even parity: total count of ones across data+parity is even.
                txBit = ^curByte;
                if (bitTick) begin
                    stateNext = STOP;
                end
            end
`endif

            STOP: begin
                txBit = 1'b1;
                if (bitTick) begin
                    if (!byteSel) begin
                        // High byte follows immediately, no idle gap.
                        byteSelNext = 1'b1;
                        stateNext   = START;
                    end else begin
                        stateNext   = IDLE;
                    end
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign tx_o      = txBit;
    assign busy_o    = (state != IDLE);
    assign stall_o   = busy_o;
    assign overrun_o = overrun;

endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx at CLKS_PER_BIT=4. Expected line
// levels are computed from the frame format (bit position arithmetic).
module tb_result_uart_tx;

    localparam int N = 4;
`ifdef RESULT_TX_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif
    localparam int TOTAL = 2 * F * N;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        done_i = 1'b0;
    logic [15:0] result_i = '0;
    logic        tx_o, busy_o, stall_o, overrun_o;

    int nCmp = 0;
    int nErr = 0;
    logic ovExp = 1'b0;

    result_uart_tx #(.CLKS_PER_BIT(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .done_i   (done_i),
        .result_i (result_i),
        .tx_o     (tx_o),
        .busy_o   (busy_o),
        .stall_o  (stall_o),
        .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Expected line level k cycles after the capture edge.
    function automatic logic expTx(input logic [15:0] w, input int k);
        int bitPos, pos;
        logic [7:0] b;
        bitPos = k / N;
        pos    = bitPos % F;
        b      = (bitPos / F == 0) ? w[7:0] : w[15:8];
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
        if (F == 11 && pos == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic checkIdle(input string tag);
        chk({tag, ".tx"}, tx_o, 1'b1);
        chk({tag, ".busy"}, busy_o, 1'b0);
        chk({tag, ".stall"}, stall_o, busy_o);
        chk({tag, ".ovr"}, overrun_o, ovExp);
    endtask

    // Call at a negedge: request capture at the next posedge.
    task automatic startWord(input logic [15:0] w);
        done_i   = 1'b1;
        result_i = w;
    endtask

    // Follow a whole two-frame transmission; optionally fire a second
    // done_i after sample injectAt. Ends on the first idle sample.
    task automatic watchWord(input string tag, input logic [15:0] w,
                             input int injectAt, input logic [15:0] injectVal);
        for (int k = 0; k < TOTAL; k++) begin
            @(negedge clk);
            chk({tag, ".tx"}, tx_o, expTx(w, k));
            chk({tag, ".busy"}, busy_o, 1'b1);
            chk({tag, ".stall"}, stall_o, busy_o);
            chk({tag, ".ovr"}, overrun_o, ovExp);
            if (k == injectAt) begin
                done_i   = 1'b1;
                result_i = injectVal;
                ovExp    = 1'b1;
            end else begin
                done_i   = 1'b0;
                result_i = 16'($urandom);
            end
        end
        @(negedge clk);
        done_i = 1'b0;
        checkIdle({tag, ".end"});
    endtask

    initial begin
        logic [15:0] w;

        // Reset held for three cycles, then idle line.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdle("rst_hold");
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkIdle("rst_idle");
        end

        // Basic send.
        startWord(16'hA55A);
        watchWord("basic", 16'hA55A, -1, 16'h0);

        // Back-to-back: second done in the first idle cycle.
        @(negedge clk);
        startWord(16'h0001);
        watchWord("b2b0", 16'h0001, -1, 16'h0);
        startWord(16'hFFFF);
        watchWord("b2b1", 16'hFFFF, -1, 16'h0);

        // Overrun: done at C+10 is dropped and flagged.
        @(negedge clk);
        startWord(16'h1234);
        watchWord("ovr", 16'h1234, 9, 16'hBEEF);
        repeat (3) begin
            @(negedge clk);
            checkIdle("ovr_sticky");
        end

        // Reset mid-frame at C+15.
        startWord(16'h00FF);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            done_i = 1'b0;
            chk("mid.tx", tx_o, expTx(16'h00FF, k));
            chk("mid.busy", busy_o, 1'b1);
            chk("mid.stall", stall_o, busy_o);
        end
        reset = 1'b1;
        ovExp = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checkIdle("mid_rst");
        @(negedge clk);
        checkIdle("mid_rst2");
        startWord(16'h0102);
        watchWord("after_rst", 16'h0102, -1, 16'h0);

        // Reset together with done: nothing captured.
        @(negedge clk);
        reset    = 1'b1;
        done_i   = 1'b1;
        result_i = 16'hDEAD;
        @(negedge clk);
        reset  = 1'b0;
        done_i = 1'b0;
        checkIdle("rst_done");
        repeat (2) begin
            @(negedge clk);
            checkIdle("rst_done_idle");
        end

        // Random words with random idle gaps (including zero).
        for (int i = 0; i < 4; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checkIdle("rnd_gap");
            end
            w = 16'($urandom);
            startWord(w);
            watchWord("rnd", w, -1, 16'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
